pipeline_stall_controller: RTL and testbench
============================================

// Module: pipeline_stall_controller
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Takes the load-use
//  stall request from the hazard detection unit, EX-stage branch-taken,
//  multi-cycle mult/div start and data-memory wait. Drives the PC and pipeline
//  register write enables, the ID/EX bubble and the IF/ID flush.
//  Enforces stall length and priority between these events.
// PARAMETERS
//  LOAD_STALL_CYCLES  1   bubbles inserted per load-use hazard (1..3)
//  MDU_LATENCY        4   EX-occupancy cycles of a mult/div (2..15)
// PORTS
//  Clk           in   1   clock, rising edge
//  Rst           in   1   synchronous, active-high reset
//  IF_ID_stall   in   1   load-use request from hazard detection (comb., ID)
//  BranchTaken   in   1   branch/jump resolved taken in EX
//  MduStart      in   1   mult/div instruction entering EX this cycle
//  MemWait       in   1   data memory not ready (MEM stage)
//  PCWrite       out  1   PC load enable
//  IF_ID_Write   out  1   IF/ID register enable
//  IF_ID_Flush   out  1   clear IF/ID to NOP
//  ID_EX_Bubble  out  1   load NOP into ID/EX (control zeroed)
//  EX_MEM_Write  out  1   EX/MEM register enable
//  MEM_WB_Write  out  1   MEM/WB register enable
//  MduBusy       out  1   high while in MDU_BUSY
//  StallCycles   out  32  stall cycle count (STALL_STATS_EN only, else 0)
//  FlushCount    out  32  flush count (STALL_STATS_EN only, else 0)
// BEHAVIOUR
//  States: RUN, LU_STALL, MDU_BUSY. Counter cnt[3:0].
//  Rst=1: state<=RUN, cnt<=0, stats<=0. All outputs 0 while Rst=1.
//  Default (RUN, no event): PCWrite=IF_ID_Write=EX_MEM_Write=MEM_WB_Write=1.
//    Flush, bubble and MduBusy are 0.
//  Priority per cycle: MemWait > BranchTaken > MDU_BUSY > MduStart > IF_ID_stall.
//  MemWait=1: freeze. All four write enables 0, no bubble, no flush.
//    State and cnt hold. Other inputs are ignored that cycle.
//  BranchTaken (RUN or LU_STALL): same cycle PCWrite=1, IF_ID_Flush=1,
//    ID_EX_Bubble=1. Next state RUN, cnt<=0. Aborts any pending load-use stall.
//  MduStart in RUN: same cycle ID_EX_Bubble=0, PCWrite=IF_ID_Write=0.
//    cnt<=MDU_LATENCY-1, next MDU_BUSY.
//  MDU_BUSY: PCWrite=IF_ID_Write=0. EX_MEM_Write=1, ID_EX_Bubble=0, MduBusy=1.
//    cnt decrements each non-frozen cycle. When cnt==1, next RUN.
//    Total front-end stall = MDU_LATENCY cycles including the MduStart cycle.
//  BranchTaken/MduStart while in MDU_BUSY: illegal (EX occupied). Ignored.
//  IF_ID_stall in RUN: same cycle PCWrite=IF_ID_Write=0, ID_EX_Bubble=1.
//    If LOAD_STALL_CYCLES>1: cnt<=LOAD_STALL_CYCLES-1, next LU_STALL.
//  LU_STALL: same outputs as the IF_ID_stall cycle. cnt decrements.
//    When cnt==1, next RUN. IF_ID_stall is ignored here.
//  All outputs combinational from state plus inputs; no added latency.
//  Stall-to-release: fetch resumes the cycle after the last stall cycle.
//  Rst mid-stall: returns to RUN next edge. No residual bubble.
// CONFIGURATION
//  STALL_STATS_EN defined:
//    StallCycles +1 on every cycle with PCWrite=0 (Rst=0).
//    FlushCount +1 on every IF_ID_Flush cycle.
//    Both wrap at 2^32 and clear on Rst.
//  STALL_STATS_EN undefined: no counter flops. Both ports driven constant 0.
// TESTING
//  1. IF_ID_stall 1 cycle, LOAD_STALL_CYCLES=1 -> PCWrite=0, Bubble=1
//     for exactly 1 cycle, then RUN defaults.
//  2. LOAD_STALL_CYCLES=2, IF_ID_stall pulse; BranchTaken on 2nd cycle
//     -> flush+bubble, PCWrite=1, state RUN, no 3rd stall cycle.
//  3. MduStart, MDU_LATENCY=4 -> PCWrite=0 for 4 cycles, MduBusy=1
//     for cycles 2-4, PCWrite=1 on cycle 5.
//  4. MemWait=1 for 3 cycles mid MDU_BUSY (cnt=2) -> all enables 0,
//     cnt holds 2; 2 more busy cycles after release.
//  5. BranchTaken and IF_ID_stall same cycle -> flush wins,
//     PCWrite=1, no LU_STALL entry.
//  6. STALL_STATS_EN: run scenarios 1+3 -> StallCycles=5, FlushCount=0;
//     assert Rst -> both 0 next cycle.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
//   Central stall/flush sequencer for the 5-stage pipeline. Arbitrates the
//   data-memory wait, EX-stage taken branch, multi-cycle mult/div and the
//   load-use hazard request, and drives the PC / pipeline register enables,
//   the ID/EX bubble and the IF/ID flush.
//
// Parameters
//   LOAD_STALL_CYCLES  bubbles inserted per load-use hazard (1..3)
//   MDU_LATENCY        EX-occupancy cycles of a mult/div (2..15)
//
// Ports
//   Clk, Rst        rising-edge clock, synchronous active-high reset
//   IF_ID_stall     load-use request from hazard detection (ID)
//   BranchTaken     branch/jump resolved taken in EX
//   MduStart        mult/div instruction entering EX this cycle
//   MemWait         data memory not ready (MEM)
//   PCWrite, IF_ID_Write, EX_MEM_Write, MEM_WB_Write   register enables
//   IF_ID_Flush     clear IF/ID to NOP
//   ID_EX_Bubble    load NOP into ID/EX
//   MduBusy         high while the mult/div occupies EX
//   StallCycles     cycles with PCWrite=0 (statistics build only, else 0)
//   FlushCount      IF_ID_Flush cycles (statistics build only, else 0)
//
// Configuration
//   STALL_STATS_EN  when defined, adds the two 32-bit statistics counters.
//
// Priority each cycle: MemWait > BranchTaken > MDU_BUSY > MduStart > IF_ID_stall.
// All outputs are combinational from the state and the current inputs.

module pipeline_stall_controller #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MDU_LATENCY       = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        IF_ID_stall,
  input  logic        BranchTaken,
  input  logic        MduStart,
  input  logic        MemWait,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Bubble,
  output logic        EX_MEM_Write,
  output logic        MEM_WB_Write,
  output logic        MduBusy,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MDU_BUSY = 2'd2
  } state_t;

  localparam logic [3:0] LU_LOAD  = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [3:0] MDU_LOAD = 4'(MDU_LATENCY - 1);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [3:0] cnt_r;
  logic [3:0] cnt_nxt_s;

  // Output decode and next-state selection by event priority.
  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    EX_MEM_Write = 1'b1;
    MEM_WB_Write = 1'b1;
    MduBusy      = 1'b0;
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;

    if (Rst) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Write = 1'b0;
      state_nxt_s  = RUN;
      cnt_nxt_s    = 4'd0;
    end else if (MemWait) begin
      // Whole pipeline frozen; state and count hold, other inputs ignored.
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Write = 1'b0;
      MduBusy      = (state_r == MDU_BUSY);
    end else begin
      case (state_r)
        MDU_BUSY: begin
          // EX is occupied: branch and a second MduStart cannot be legal here.
          PCWrite     = 1'b0;
          IF_ID_Write = 1'b0;
          MduBusy     = 1'b1;
          if (cnt_r == 4'd1) begin
            state_nxt_s = RUN;
            cnt_nxt_s   = 4'd0;
          end else begin
            cnt_nxt_s = cnt_r - 4'd1;
          end
        end
        LU_STALL: begin
          if (BranchTaken) begin
            // Taken branch abandons the remaining load-use bubbles.
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
            state_nxt_s  = RUN;
            cnt_nxt_s    = 4'd0;
          end else begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            if (cnt_r == 4'd1) begin
              state_nxt_s = RUN;
              cnt_nxt_s   = 4'd0;
            end else begin
              cnt_nxt_s = cnt_r - 4'd1;
            end
          end
        end
        RUN: begin
          if (BranchTaken) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
            state_nxt_s  = RUN;
            cnt_nxt_s    = 4'd0;
          end else if (MduStart) begin
            // The MduStart cycle itself is the first of MDU_LATENCY stall cycles.
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            state_nxt_s = MDU_BUSY;
            cnt_nxt_s   = MDU_LOAD;
          end else if (IF_ID_stall) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_nxt_s = LU_STALL;
              cnt_nxt_s   = LU_LOAD;
            end else begin
              state_nxt_s = RUN;
            end
          end else begin
            state_nxt_s = RUN;
          end
        end
        default: begin
          state_nxt_s = RUN;
          cnt_nxt_s   = 4'd0;
        end
      endcase
    end
  end

  // State and stall counter registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r <= RUN;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

`ifdef STALL_STATS_EN
  logic [31:0] stall_cycles_r;
  logic [31:0] flush_count_r;

  // Statistics counters; wrap naturally at 2^32.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_cycles_r <= 32'd0;
      flush_count_r  <= 32'd0;
    end else begin
      if (!PCWrite) begin
        stall_cycles_r <= stall_cycles_r + 32'd1;
      end
      if (IF_ID_Flush) begin
        flush_count_r <= flush_count_r + 32'd1;
      end
    end
  end

  assign StallCycles = stall_cycles_r;
  assign FlushCount  = flush_count_r;
`else
  assign StallCycles = 32'd0;
  assign FlushCount  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Testbench for pipeline_stall_controller. Two instances (load-use 1 / MDU 4
// and load-use 2 / MDU 5) share the inputs. Every cycle both are compared
// against a remaining-stall-cycles reference model; table rows and short
// hand sequences additionally carry fixed expected vectors.
// Output vector order: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble,
//                       EX_MEM_Write, MEM_WB_Write, MduBusy}
// Input vector order:  {Rst, IF_ID_stall, BranchTaken, MduStart, MemWait}

module tb_pipeline_stall_controller;

  localparam int LSC0 = 1;
  localparam int LAT0 = 4;
  localparam int LSC1 = 2;
  localparam int LAT1 = 5;

  logic Clk = 1'b0;
  logic Rst, IF_ID_stall, BranchTaken, MduStart, MemWait;
  logic [1:0] pcw, ifw, fl, bub, exw, mww, busy;
  logic [31:0] sc0, sc1, fc0, fc1;

  int checks = 0;
  int errors = 0;

  // Reference model: how many further stall cycles each kind still owes.
  int          lu_left  [2];
  int          mdu_left [2];
  logic [31:0] m_sc     [2];
  logic [31:0] m_fc     [2];

  typedef struct {
    logic [4:0] in;
    logic [6:0] exp;
  } vec_t;
  vec_t tbl[$];

  always #5 Clk = ~Clk;

  pipeline_stall_controller #(.LOAD_STALL_CYCLES(LSC0), .MDU_LATENCY(LAT0)) dut0 (
    .Clk(Clk), .Rst(Rst), .IF_ID_stall(IF_ID_stall), .BranchTaken(BranchTaken),
    .MduStart(MduStart), .MemWait(MemWait), .PCWrite(pcw[0]), .IF_ID_Write(ifw[0]),
    .IF_ID_Flush(fl[0]), .ID_EX_Bubble(bub[0]), .EX_MEM_Write(exw[0]),
    .MEM_WB_Write(mww[0]), .MduBusy(busy[0]), .StallCycles(sc0), .FlushCount(fc0));

  pipeline_stall_controller #(.LOAD_STALL_CYCLES(LSC1), .MDU_LATENCY(LAT1)) dut1 (
    .Clk(Clk), .Rst(Rst), .IF_ID_stall(IF_ID_stall), .BranchTaken(BranchTaken),
    .MduStart(MduStart), .MemWait(MemWait), .PCWrite(pcw[1]), .IF_ID_Write(ifw[1]),
    .IF_ID_Flush(fl[1]), .ID_EX_Bubble(bub[1]), .EX_MEM_Write(exw[1]),
    .MEM_WB_Write(mww[1]), .MduBusy(busy[1]), .StallCycles(sc1), .FlushCount(fc1));

  function automatic logic [6:0] dut_vec(input int k);
    return {pcw[k], ifw[k], fl[k], bub[k], exw[k], mww[k], busy[k]};
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Model evaluation for one instance: returns expected outputs, advances state.
  task automatic model_step(input int k, output logic [6:0] e);
    int lsc = (k == 0) ? LSC0 : LSC1;
    int lat = (k == 0) ? LAT0 : LAT1;
    if (Rst) begin
      e = 7'b0000000;
      lu_left[k] = 0;
      mdu_left[k] = 0;
      m_sc[k] = 32'd0;
      m_fc[k] = 32'd0;
    end else begin
      if (MemWait)             e = {6'b000000, (mdu_left[k] > 0)};
      else if (mdu_left[k] > 0) begin e = 7'b0000111; mdu_left[k]--; end
      else if (BranchTaken)     begin e = 7'b1111110; lu_left[k] = 0; end
      else if (lu_left[k] > 0)  begin e = 7'b0001110; lu_left[k]--; end
      else if (MduStart)        begin e = 7'b0000110; mdu_left[k] = lat - 1; end
      else if (IF_ID_stall)     begin e = 7'b0001110; lu_left[k] = lsc - 1; end
      else                      e = 7'b1100110;
      if (!e[6]) m_sc[k] = m_sc[k] + 32'd1;
      if (e[4])  m_fc[k] = m_fc[k] + 32'd1;
    end
  endtask

  // Drive one cycle at the falling edge, compare mid-cycle, optionally check a
  // fixed expected vector on instance k.
  task automatic apply(input logic [4:0] in, input logic chk, input int k,
                       input logic [6:0] exp, input string name);
    logic [6:0] e;
    {Rst, IF_ID_stall, BranchTaken, MduStart, MemWait} = in;
    #1;
`ifdef STALL_STATS_EN
    cmp("stall_cycles0", sc0, m_sc[0]);
    cmp("flush_count0",  fc0, m_fc[0]);
    cmp("stall_cycles1", sc1, m_sc[1]);
    cmp("flush_count1",  fc1, m_fc[1]);
`else
    cmp("stats_zero", sc0 | fc0 | sc1 | fc1, 32'd0);
`endif
    for (int j = 0; j < 2; j++) begin
      model_step(j, e);
      cmp($sformatf("model_outs%0d", j), {25'd0, dut_vec(j)}, {25'd0, e});
    end
    if (chk) cmp(name, {25'd0, dut_vec(k)}, {25'd0, exp});
    @(negedge Clk);
  endtask

  initial begin
    {Rst, IF_ID_stall, BranchTaken, MduStart, MemWait} = 5'b10000;
    for (int j = 0; j < 2; j++) begin
      lu_left[j] = 0; mdu_left[j] = 0; m_sc[j] = 32'd0; m_fc[j] = 32'd0;
    end
    @(negedge Clk);

    // Table for the default instance (load-use 1, MDU latency 4).
    tbl.push_back('{5'b10000, 7'b0000000}); // 0 reset
    tbl.push_back('{5'b01000, 7'b0001110}); // 1 load-use stall
    tbl.push_back('{5'b00000, 7'b1100110}); // 2 released
    tbl.push_back('{5'b00010, 7'b0000110}); // 3 MduStart
    tbl.push_back('{5'b00000, 7'b0000111}); // 4 busy
    tbl.push_back('{5'b00000, 7'b0000111}); // 5 busy
    tbl.push_back('{5'b00000, 7'b0000111}); // 6 busy
    tbl.push_back('{5'b00000, 7'b1100110}); // 7 fetch resumes
    tbl.push_back('{5'b10000, 7'b0000000}); // 8 reset
    tbl.push_back('{5'b00000, 7'b1100110}); // 9 idle
    tbl.push_back('{5'b01100, 7'b1111110}); // 10 branch + load-use: flush wins
    tbl.push_back('{5'b00000, 7'b1100110}); // 11 no LU_STALL entry
    tbl.push_back('{5'b00010, 7'b0000110}); // 12 MduStart
    tbl.push_back('{5'b00000, 7'b0000111}); // 13 busy, cnt 3->2
    tbl.push_back('{5'b00001, 7'b0000001}); // 14 freeze
    tbl.push_back('{5'b00001, 7'b0000001}); // 15 freeze
    tbl.push_back('{5'b00001, 7'b0000001}); // 16 freeze
    tbl.push_back('{5'b00110, 7'b0000111}); // 17 busy, illegal branch/start ignored
    tbl.push_back('{5'b00000, 7'b0000111}); // 18 last busy
    tbl.push_back('{5'b00000, 7'b1100110}); // 19 released
    tbl.push_back('{5'b00101, 7'b0000000}); // 20 MemWait beats branch
    tbl.push_back('{5'b00000, 7'b1100110}); // 21 idle
    tbl.push_back('{5'b00010, 7'b0000110}); // 22 MduStart
    tbl.push_back('{5'b00000, 7'b0000111}); // 23 busy
    tbl.push_back('{5'b10000, 7'b0000000}); // 24 reset mid-stall
    tbl.push_back('{5'b00000, 7'b1100110}); // 25 no residual stall
    tbl.push_back('{5'b01010, 7'b0000110}); // 26 MduStart beats load-use
    tbl.push_back('{5'b00000, 7'b0000111}); // 27
    tbl.push_back('{5'b00000, 7'b0000111}); // 28
    tbl.push_back('{5'b00000, 7'b0000111}); // 29
    tbl.push_back('{5'b00000, 7'b1100110}); // 30

    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 7 || i == 9) begin
        // Rows 1..6 hold 5 stall cycles and no flush; row 8 resets them.
        {Rst, IF_ID_stall, BranchTaken, MduStart, MemWait} = tbl[i].in;
        #1;
`ifdef STALL_STATS_EN
        cmp($sformatf("stats_sc_row%0d", i), sc0, (i == 7) ? 32'd5 : 32'd0);
        cmp($sformatf("stats_fc_row%0d", i), fc0, 32'd0);
`else
        cmp($sformatf("stats_off_row%0d", i), sc0 | fc0, 32'd0);
`endif
      end
      apply(tbl[i].in, 1'b1, 0, tbl[i].exp, $sformatf("table_row%0d", i));
    end

    // Load-use 2 instance: full two-cycle stall, then branch on 2nd cycle.
    apply(5'b10000, 1'b1, 1, 7'b0000000, "lu2_reset");
    apply(5'b01000, 1'b1, 1, 7'b0001110, "lu2_stall1");
    apply(5'b00000, 1'b1, 1, 7'b0001110, "lu2_stall2");
    apply(5'b00000, 1'b1, 1, 7'b1100110, "lu2_release");
    apply(5'b01000, 1'b1, 1, 7'b0001110, "lu2b_stall1");
    apply(5'b00100, 1'b1, 1, 7'b1111110, "lu2b_branch");
    apply(5'b00000, 1'b1, 1, 7'b1100110, "lu2b_no_third");
    apply(5'b01000, 1'b1, 1, 7'b0001110, "lu2c_stall1");
    apply(5'b00001, 1'b1, 1, 7'b0000000, "lu2c_freeze");
    apply(5'b00000, 1'b1, 1, 7'b0001110, "lu2c_stall2");
    apply(5'b00000, 1'b1, 1, 7'b1100110, "lu2c_release");

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] r;
      r[4] = ($urandom_range(0, 63) == 0);
      r[3] = ($urandom_range(0, 3) == 0);
      r[2] = ($urandom_range(0, 5) == 0);
      r[1] = ($urandom_range(0, 5) == 0);
      r[0] = ($urandom_range(0, 4) == 0);
      apply(r, 1'b0, 0, 7'b0000000, "");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
